// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD definitions: FSM states, digit limits, digit-valid checks
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int         BCD_DIGITS    = 4;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   function automatic logic digit_ok(input logic [3:0] n);
      return n <= BCD_MAX_DIGIT;
   endfunction

   function automatic logic word_ok(input logic [4*BCD_DIGITS-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         ok = ok & digit_ok(v[4*i +: 4]);
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - one BCD digit of subtraction with borrow in/out
module bcd_digit_sub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic signed [4:0] t;

   // Bit 4 is the sign of a - b - bin; a negative step borrows ten from the next digit.
   always_comb begin
      t    = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
      bout = t[4];
      d    = bout ? (t[3:0] + 4'd10) : t[3:0];
   end

endmodule

// File: rtl/bcd_sub_16_seq.sv
// rtl/bcd_sub_16_seq.sv - sequential 4-digit packed-BCD subtractor, one digit per clock
module bcd_sub_16_seq
   import bcd_pkg::*;
#(
   parameter bit SATURATE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] diff,
   output logic        uflow,
   output logic        err
);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        borrow_q, borrow_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [15:0] res_q, res_d;
   logic [15:0] diff_q, diff_d;
   logic        uflow_q, uflow_d;
   logic        err_q, err_d;

   logic [3:0]  xd, yd, dig;
   logic        bout;
   logic [15:0] raw;

   assign xd  = x_q[{idx_q, 2'b00} +: 4];
   assign yd  = y_q[{idx_q, 2'b00} +: 4];
   assign raw = {dig, res_q[11:0]};

   bcd_digit_sub u_digit (
      .a    (xd),
      .b    (yd),
      .bin  (borrow_q),
      .d    (dig),
      .bout (bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         borrow_q <= 1'b0;
         x_q      <= 16'h0000;
         y_q      <= 16'h0000;
         res_q    <= 16'h0000;
         diff_q   <= 16'h0000;
         uflow_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         x_q      <= x_d;
         y_q      <= y_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         uflow_q  <= uflow_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)        state_d = ST_CALC;
         ST_CALC: if (idx_q == 2'd3)   state_d = ST_DONE;
         ST_DONE: if (out_ready)       state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      idx_d    = idx_q;
      borrow_d = borrow_q;
      x_d      = x_q;
      y_d      = y_q;
      res_d    = res_q;
      diff_d   = diff_q;
      uflow_d  = uflow_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d      = x;
               y_d      = y;
               idx_d    = 2'd0;
               borrow_d = 1'b0;
               res_d    = 16'h0000;
               err_d    = !(word_ok(x) && word_ok(y));
            end
         end
         ST_CALC: begin
            res_d[{idx_q, 2'b00} +: 4] = dig;
            borrow_d = bout;
            idx_d    = idx_q + 2'd1;
            // Final digit: the output word is resolved here so DONE only holds registers.
            if (idx_q == 2'd3) begin
               uflow_d = bout & ~err_q;
               if (err_q || (bout && SATURATE)) diff_d = 16'h0000;
               else                             diff_d = raw;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   assign diff  = diff_q;
   assign uflow = uflow_q;
   assign err   = err_q;

endmodule

// File: tb/tb_bcd_sub_16_seq.sv
// tb/tb_bcd_sub_16_seq.sv - bench for bcd_sub_16_seq, saturating and wrapping builds side by side
module tb_bcd_sub_16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] x, y;

   logic        in_ready_s, out_valid_s, uflow_s, err_s;
   logic [15:0] diff_s;
   logic        in_ready_w, out_valid_w, uflow_w, err_w;
   logic [15:0] diff_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_sub_16_seq #(.SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .x(x), .y(y), .out_valid(out_valid_s), .out_ready(out_ready),
      .diff(diff_s), .uflow(uflow_s), .err(err_s)
   );

   bcd_sub_16_seq #(.SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .x(x), .y(y), .out_valid(out_valid_w), .out_ready(out_ready),
      .diff(diff_w), .uflow(uflow_w), .err(err_w)
   );

   task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   // Returns {err, uflow, diff} from decimal arithmetic on the operands.
   function automatic logic [17:0] model(input logic [15:0] xv, input logic [15:0] yv, input bit sat);
      logic bad;
      int   xi, yi;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (xv[4*i +: 4] > 4'd9 || yv[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      xi = bcd2int(xv);
      yi = bcd2int(yv);
      if (bad)           return {1'b1, 1'b0, 16'h0000};
      else if (xi < yi)  return {1'b0, 1'b1, sat ? 16'h0000 : int2bcd(10000 + xi - yi)};
      else               return {1'b0, 1'b0, int2bcd(xi - yi)};
   endfunction

   task automatic check_outputs(input logic [17:0] es, input logic [17:0] ew, input string tag);
      chk(diff_s,  es[15:0], {tag, " diff_sat"});
      chk(16'(uflow_s), 16'(es[16]), {tag, " uflow_sat"});
      chk(16'(err_s),   16'(es[17]), {tag, " err_sat"});
      chk(diff_w,  ew[15:0], {tag, " diff_wrap"});
      chk(16'(uflow_w), 16'(ew[16]), {tag, " uflow_wrap"});
      chk(16'(err_w),   16'(ew[17]), {tag, " err_wrap"});
   endtask

   task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input int hold, input string tag);
      logic [17:0] es, ew;
      int cnt;
      es = model(xv, yv, 1'b1);
      ew = model(xv, yv, 1'b0);
      chk(16'(in_ready_s), 16'd1, {tag, " in_ready before"});
      x = xv; y = yv; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = 16'($urandom); y = 16'($urandom);
      cnt = 0;
      while (!out_valid_s && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk(16'(cnt), 16'd4, {tag, " latency"});
      chk(16'(out_valid_w), 16'd1, {tag, " out_valid_wrap"});
      check_outputs(es, ew, tag);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; x = 16'h9999; y = 16'h0000;
         @(posedge clk); #1;
         chk(16'(out_valid_s), 16'd1, {tag, " held out_valid"});
         chk(16'(in_ready_s),  16'd0, {tag, " held in_ready"});
         check_outputs(es, ew, {tag, " held"});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk(16'(out_valid_s), 16'd0, {tag, " out_valid after handshake"});
      chk(16'(in_ready_s),  16'd1, {tag, " in_ready after handshake"});
      chk(16'(in_ready_w),  16'd1, {tag, " in_ready_wrap after handshake"});
   endtask

   initial begin
      logic [15:0] rx, ry;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(16'(in_ready_s),  16'd1, "reset in_ready");
      chk(16'(out_valid_s), 16'd0, "reset out_valid");
      chk(diff_s,           16'h0000, "reset diff");
      chk(16'(uflow_s),     16'd0, "reset uflow");
      chk(16'(err_s),       16'd0, "reset err");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h5432, 16'h1234, 0, "basic");
      chk(diff_s, 16'h4198, "basic literal diff");
      run_op(16'h1000, 16'h0001, 0, "borrow_chain");
      run_op(16'h0001, 16'h0002, 0, "underflow");
      chk(diff_w, 16'h9999, "underflow literal wrap");
      run_op(16'h12A4, 16'h0001, 0, "bad_nibble");
      run_op(16'h9999, 16'h9999, 0, "equal");
      run_op(16'h8765, 16'h0123, 5, "backpressure");
      run_op(16'h0000, 16'h9999, 1, "max_underflow");

      // Abort a run carrying err=1 after digit 1, then confirm a clean restart.
      x = 16'h3F21; y = 16'h0011; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk(16'(in_ready_s),  16'd1, "midreset in_ready");
      chk(16'(out_valid_s), 16'd0, "midreset out_valid");
      chk(diff_s,           16'h0000, "midreset diff");
      chk(16'(uflow_s),     16'd0, "midreset uflow");
      chk(16'(err_s),       16'd0, "midreset err");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0050, 16'h0025, 0, "after_reset");
      chk(diff_s, 16'h0025, "after_reset literal diff");

      for (int n = 0; n < 12; n++) begin
         for (int d = 0; d < 4; d++) begin
            rx[4*d +: 4] = 4'($urandom_range(0, 9));
            ry[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) rx[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 7) == 0) ry[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         run_op(rx, ry, $urandom_range(0, 2), $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
